// File: rtl/fft_pkg.sv
// Shared FFT definitions: bank count, default geometry, unload FSM states and
// an index bit-reversal helper.
package fft_pkg;

  localparam int unsigned BANK_NUM   = 4;
  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned N_POINT    = BANK_NUM * (1 << DEF_ADDR_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } unload_state_t;

  // Reverse the low w bits of x; bits at and above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] x, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) r[5'(i)] = x[5'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_unload_fifo.sv
// Small synchronous FIFO holding read-back samples until the consumer takes them.
// Ports: clk, rst_n (async active-low), push/wr_data, pop/rd_data (head, look-ahead),
//        full, empty, count.
module fft_unload_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fft_unload.sv
// FFT result reader: once the transform is done, walks all N points, reads each
// from its physical bank (after the output bank rotation) and streams complex
// samples in natural index order over valid/ready.
// Optional build macro FFT_BITREV_EN: read index is the bit-reverse of the sample
// counter so a decimation-in-frequency result still leaves in natural order.
// Ports:
//   iCLK, iRESET (async active-low)
//   iSTART, iBANK_ROT            start pulse and bank rotation (latched on start)
//   oADDR_RD, oBANK_SEL, oRD_EN  bank read request (registered)
//   iDATA_RE_0..3, iDATA_IM_0..3 bank read data, RD_LAT cycles after the request
//   oDATA_RE, oDATA_IM, oLAST, oVALID, iREADY  output stream
//   oBUSY, oDONE                 owns bank read ports / completion pulse
module fft_unload
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned FIFO_D = 4
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iSTART,
  input  logic [1:0]        iBANK_ROT,
  output logic [ADDR_W-1:0] oADDR_RD,
  output logic [1:0]        oBANK_SEL,
  output logic              oRD_EN,
  input  logic [DATA_W-1:0] iDATA_RE_0,
  input  logic [DATA_W-1:0] iDATA_RE_1,
  input  logic [DATA_W-1:0] iDATA_RE_2,
  input  logic [DATA_W-1:0] iDATA_RE_3,
  input  logic [DATA_W-1:0] iDATA_IM_0,
  input  logic [DATA_W-1:0] iDATA_IM_1,
  input  logic [DATA_W-1:0] iDATA_IM_2,
  input  logic [DATA_W-1:0] iDATA_IM_3,
  output logic [DATA_W-1:0] oDATA_RE,
  output logic [DATA_W-1:0] oDATA_IM,
  output logic              oVALID,
  input  logic              iREADY,
  output logic              oLAST,
  output logic              oBUSY,
  output logic              oDONE
);

  localparam int unsigned K_W   = ADDR_W + 2;
  localparam int unsigned N     = BANK_NUM << ADDR_W;
  localparam int unsigned ENT_W = 2 * DATA_W + 1;
  localparam int unsigned CNT_W = $clog2(FIFO_D + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

  if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_lat
    $error("fft_unload: RD_LAT must be 1 or 2");
  end
  if (FIFO_D < RD_LAT + 2) begin : g_bad_depth
    $error("fft_unload: FIFO_D must be at least RD_LAT + 2");
  end

  unload_state_t     state_q, state_d;
  logic [1:0]        rot_q, rot_d;
  logic [K_W-1:0]    k_q, k_d, j;
  logic              busy_d, done_d, issue, credit_ok;
  logic [CNT_W-1:0]  inflight_q, fifo_cnt;
  logic              last_iss_q;
  logic              pv_q [RD_LAT];
  logic [1:0]        pb_q [RD_LAT];
  logic              pl_q [RD_LAT];
  logic              push, pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] rd_re, rd_im;
  logic [ENT_W-1:0]  rd_ent;

  // Only issue a read if its sample is guaranteed a FIFO slot on return.
  assign credit_ok = (SUM_W'(fifo_cnt) + SUM_W'(inflight_q)) < SUM_W'(FIFO_D);

`ifdef FFT_BITREV_EN
  assign j = K_W'(bitrev(32'(k_q), K_W));
`else
  assign j = k_q;
`endif

  // Next-state and issue decision.
  always_comb begin
    state_d = state_q;
    rot_d   = rot_q;
    k_d     = k_q;
    busy_d  = oBUSY;
    done_d  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (iSTART) begin
          state_d = RUN;
          rot_d   = iBANK_ROT;
          k_d     = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (k_q == K_LAST) state_d = DRAIN;
          else               k_d     = k_q + K_W'(1);
        end
      end
      DRAIN: begin
        // The last-flagged sample is the final one; its acceptance ends the unload.
        if (pop && rd_ent[ENT_W-1]) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, issue registers and return-path sideband pipeline.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q    <= IDLE;
      rot_q      <= '0;
      k_q        <= '0;
      oBUSY      <= 1'b0;
      oDONE      <= 1'b0;
      oRD_EN     <= 1'b0;
      oADDR_RD   <= '0;
      oBANK_SEL  <= '0;
      last_iss_q <= 1'b0;
      inflight_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pb_q[i] <= '0;
        pl_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      rot_q   <= rot_d;
      k_q     <= k_d;
      oBUSY   <= busy_d;
      oDONE   <= done_d;
      oRD_EN  <= issue;
      if (issue) begin
        oADDR_RD   <= j[K_W-1:2];
        oBANK_SEL  <= j[1:0] + rot_q;
        last_iss_q <= (k_q == K_LAST);
      end
      pv_q[0] <= oRD_EN;
      pb_q[0] <= oBANK_SEL;
      pl_q[0] <= last_iss_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pb_q[i] <= pb_q[i-1];
        pl_q[i] <= pl_q[i-1];
      end
      case ({issue, push})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign push = pv_q[RD_LAT-1];
  assign pop  = oVALID & iREADY;

  // Select the bank whose read is returning this cycle.
  always_comb begin
    rd_re = iDATA_RE_0;
    rd_im = iDATA_IM_0;
    case (pb_q[RD_LAT-1])
      2'd1:    begin rd_re = iDATA_RE_1; rd_im = iDATA_IM_1; end
      2'd2:    begin rd_re = iDATA_RE_2; rd_im = iDATA_IM_2; end
      2'd3:    begin rd_re = iDATA_RE_3; rd_im = iDATA_IM_3; end
      default: begin rd_re = iDATA_RE_0; rd_im = iDATA_IM_0; end
    endcase
  end

  fft_unload_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk     (iCLK),
    .rst_n   (iRESET),
    .push    (push),
    .wr_data ({pl_q[RD_LAT-1], rd_im, rd_re}),
    .pop     (pop),
    .rd_data (rd_ent),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign oVALID   = ~fifo_empty;
  assign oLAST    = rd_ent[ENT_W-1];
  assign oDATA_IM = rd_ent[2*DATA_W-1:DATA_W];
  assign oDATA_RE = rd_ent[DATA_W-1:0];

`ifndef SYNTHESIS
  // The credit rule must keep returning reads from ever meeting a full FIFO.
  always_ff @(posedge iCLK) begin
    if (iRESET) assert (!(push && fifo_full)) else $error("fft_unload: FIFO overflow");
  end
`endif

endmodule
